// File: rtl/enigma_pkg.sv
// Shared types and widths for the enigma output stage.
package enigma_pkg;

   localparam int SYMB_W = 7;
   localparam int CNT_W  = 8;

   typedef logic signed [SYMB_W-1:0] symbol_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } msgbuf_state_t;

endpackage

// File: rtl/enigma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO for cipher symbols.
// Full/empty come from an occupancy counter, so the pointers simply wrap.
// A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
module enigma_sync_fifo
   import enigma_pkg::*;
#(
   parameter int DEPTH = 16
)
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  symbol_t                wdata_i,
   output symbol_t                rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   symbol_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level;
   logic             push_ok;
   logic             pop_ok;

   assign empty_o = (level == '0);
   assign full_o  = (level == LVL_W'(DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   assign level_o = level;

   // Head is forced to zero while empty so the output is clean out of reset.
   assign rdata_o = empty_o ? '0 : mem[rd_ptr];

   // Pointer and occupancy update; flush discards everything in one cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) mem[wr_ptr] <= wdata_i;
   end

endmodule

// File: rtl/enigma_msg_buffer.sv
// Output stage behind the cipher core: buffers one message of symbols and
// releases it under valid/ready, flagging symbols lost to a full FIFO.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | no message; symb_val_i ignored, waiting for start_i
//  COLLECT | accepting symbols until len have been seen (kept or dropped)
//  DRAIN   | input closed; waiting for every kept symbol to be popped
//  DONE    | one-cycle msg_done_o pulse, then back to IDLE
module enigma_msg_buffer
   import enigma_pkg::*;
#(
   parameter int DEPTH = 16
)
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [CNT_W-1:0]       symb_numb_i,
   input  logic                   symb_val_i,
   input  symbol_t                symbol_i,
   input  logic                   out_ready_i,
   output logic                   out_val_o,
   output symbol_t                symbol_o,
   output logic                   msg_done_o,
   output logic                   overflow_o,
   output logic                   busy_o,
   output logic [$clog2(DEPTH):0] level_o
);

   msgbuf_state_t    state, state_nxt;
   logic [CNT_W-1:0] len, len_nxt;
   logic [CNT_W-1:0] rx_cnt, rx_nxt;
   logic [CNT_W-1:0] tx_cnt, tx_nxt;
   logic [CNT_W-1:0] dropped, dropped_nxt;
   logic             overflow, overflow_nxt;

   logic             fifo_push;
   logic             fifo_flush;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop_fire;

   enigma_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (fifo_flush),
      .push_i  (fifo_push),
      .pop_i   (out_ready_i),
      .wdata_i (symbol_i),
      .rdata_o (symbol_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o)
   );

   assign out_val_o  = !fifo_empty;
   assign pop_fire   = out_val_o && out_ready_i;
   assign msg_done_o = (state == DONE);
   assign busy_o     = (state != IDLE);
   assign overflow_o = overflow;

   // State and message counters.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         len      <= '0;
         rx_cnt   <= '0;
         tx_cnt   <= '0;
         dropped  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         len      <= len_nxt;
         rx_cnt   <= rx_nxt;
         tx_cnt   <= tx_nxt;
         dropped  <= dropped_nxt;
         overflow <= overflow_nxt;
      end
   end

   // Next-state, counter and FIFO control. A start in DONE is ignored so the
   // finishing message always gets its pulse.
   always_comb begin
      state_nxt    = state;
      len_nxt      = len;
      rx_nxt       = rx_cnt;
      tx_nxt       = tx_cnt;
      dropped_nxt  = dropped;
      overflow_nxt = overflow;
      fifo_push    = 1'b0;
      fifo_flush   = 1'b0;

      if (pop_fire) tx_nxt = tx_cnt + CNT_W'(1);

      if (start_i && state != DONE) begin
         len_nxt      = symb_numb_i;
         rx_nxt       = '0;
         tx_nxt       = '0;
         dropped_nxt  = '0;
         overflow_nxt = 1'b0;
         fifo_flush   = (state != IDLE);
         state_nxt    = (symb_numb_i == '0) ? DONE : COLLECT;
      end else begin
         unique case (state)
            COLLECT: begin
               if (symb_val_i) begin
                  fifo_push = 1'b1;
                  rx_nxt    = rx_cnt + CNT_W'(1);
                  if (fifo_full && !pop_fire) begin
                     overflow_nxt = 1'b1;
                     dropped_nxt  = dropped + CNT_W'(1);
                  end
                  if (rx_nxt == len) state_nxt = DRAIN;
               end
            end
            DRAIN: begin
               if ((tx_cnt == rx_cnt - dropped) && fifo_empty) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_enigma_msg_buffer.sv
// Directed bench for enigma_msg_buffer. Inputs change and outputs are sampled
// on the falling edge; the design works on the rising edge.
module tb_enigma_msg_buffer;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              start_i = 1'b0;
   logic [7:0]        symb_numb_i = '0;
   logic              symb_val_i = 1'b0;
   logic signed [6:0] symbol_i = '0;
   logic              out_ready_i = 1'b0;
   logic              out_val_o;
   logic signed [6:0] symbol_o;
   logic              msg_done_o;
   logic              overflow_o;
   logic              busy_o;
   logic [4:0]        level_o;

   int errors = 0;
   int checks = 0;

   enigma_msg_buffer #(.DEPTH(16)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .symb_numb_i (symb_numb_i),
      .symb_val_i  (symb_val_i),
      .symbol_i    (symbol_i),
      .out_ready_i (out_ready_i),
      .out_val_o   (out_val_o),
      .symbol_o    (symbol_o),
      .msg_done_o  (msg_done_o),
      .overflow_o  (overflow_o),
      .busy_o      (busy_o),
      .level_o     (level_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cycle();
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (3) cycle();
      rst_i = 1'b1;
      cycle();
      checks++; if (out_val_o !== 1'b0) begin errors++; $display("FAIL reset_out_val got %0b want 0", out_val_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_o); end
      checks++; if (msg_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", msg_done_o); end
      checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level_o); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow_o); end
      checks++; if (symbol_o !== 7'sd0) begin errors++; $display("FAIL reset_symbol got %0d want 0", symbol_o); end
   endtask

   task automatic test_basic();
      int vec [5] = '{-3, 0, 12, -64, 63};
      int dones = 0;
      int extra = 0;
      start_i = 1'b1; symb_numb_i = 8'd5; out_ready_i = 1'b1;
      cycle();
      start_i = 1'b0;
      for (int i = 0; i <= 5; i++) begin
         if (i > 0) begin
            checks++; if (out_val_o !== 1'b1) begin errors++; $display("FAIL basic_val[%0d] got %0b want 1", i - 1, out_val_o); end
            checks++; if (symbol_o !== 7'(vec[i-1])) begin errors++; $display("FAIL basic_data[%0d] got %0d want %0d", i - 1, symbol_o, 7'(vec[i-1])); end
         end
         if (msg_done_o) dones++;
         if (i < 5) begin symb_val_i = 1'b1; symbol_i = 7'(vec[i]); end
         else symb_val_i = 1'b0;
         cycle();
      end
      for (int n = 0; n < 8; n++) begin
         if (out_val_o) extra++;
         if (msg_done_o) dones++;
         cycle();
      end
      checks++; if (extra !== 0) begin errors++; $display("FAIL basic_extra_out got %0d want 0", extra); end
      checks++; if (dones !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", dones); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL basic_overflow got %0b want 0", overflow_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %0b want 0", busy_o); end
   endtask

   task automatic test_overflow();
      int k = 0;
      int dones = 0;
      start_i = 1'b1; symb_numb_i = 8'd20; out_ready_i = 1'b0;
      cycle();
      start_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         symb_val_i = 1'b1; symbol_i = 7'(i * 3 - 30);
         cycle();
      end
      symb_val_i = 1'b0;
      checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", level_o); end
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow_o); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ovf_busy got %0b want 1", busy_o); end
      out_ready_i = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if (out_val_o) begin
            checks++; if (symbol_o !== 7'(k * 3 - 30)) begin errors++; $display("FAIL ovf_data[%0d] got %0d want %0d", k, symbol_o, 7'(k * 3 - 30)); end
            k++;
         end
         if (msg_done_o) dones++;
         cycle();
      end
      checks++; if (k !== 16) begin errors++; $display("FAIL ovf_out_count got %0d want 16", k); end
      checks++; if (dones !== 1) begin errors++; $display("FAIL ovf_done_pulses got %0d want 1", dones); end
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow_o); end
   endtask

   task automatic test_full_push_pop();
      int k = 0;
      int dones = 0;
      start_i = 1'b1; symb_numb_i = 8'd20; out_ready_i = 1'b0;
      cycle();
      start_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         symb_val_i = 1'b1; symbol_i = 7'(10 + i);
         cycle();
      end
      checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL full_level got %0d want 16", level_o); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL full_overflow_cleared got %0b want 0", overflow_o); end
      for (int i = 16; i < 20; i++) begin
         checks++; if (symbol_o !== 7'(10 + k)) begin errors++; $display("FAIL full_data[%0d] got %0d want %0d", k, symbol_o, 7'(10 + k)); end
         k++;
         symb_val_i = 1'b1; symbol_i = 7'(10 + i); out_ready_i = 1'b1;
         cycle();
         checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL full_pp_level[%0d] got %0d want 16", i, level_o); end
         checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL full_pp_overflow[%0d] got %0b want 0", i, overflow_o); end
      end
      symb_val_i = 1'b0;
      for (int n = 0; n < 30; n++) begin
         if (out_val_o) begin
            checks++; if (symbol_o !== 7'(10 + k)) begin errors++; $display("FAIL full_data[%0d] got %0d want %0d", k, symbol_o, 7'(10 + k)); end
            k++;
         end
         if (msg_done_o) dones++;
         cycle();
      end
      checks++; if (k !== 20) begin errors++; $display("FAIL full_out_count got %0d want 20", k); end
      checks++; if (dones !== 1) begin errors++; $display("FAIL full_done_pulses got %0d want 1", dones); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL full_overflow_end got %0b want 0", overflow_o); end
   endtask

   task automatic test_empty_msg();
      start_i = 1'b1; symb_numb_i = 8'd0;
      cycle();
      start_i = 1'b0;
      checks++; if (msg_done_o !== 1'b1) begin errors++; $display("FAIL empty_done got %0b want 1", msg_done_o); end
      checks++; if (out_val_o !== 1'b0) begin errors++; $display("FAIL empty_out_val got %0b want 0", out_val_o); end
      cycle();
      checks++; if (msg_done_o !== 1'b0) begin errors++; $display("FAIL empty_done_width got %0b want 0", msg_done_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL empty_busy got %0b want 0", busy_o); end
      checks++; if (out_val_o !== 1'b0) begin errors++; $display("FAIL empty_out_val2 got %0b want 0", out_val_o); end
   endtask

   task automatic test_abort();
      int dones = 0;
      int extra = 0;
      start_i = 1'b1; symb_numb_i = 8'd10; out_ready_i = 1'b0;
      cycle();
      start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         symb_val_i = 1'b1; symbol_i = 7'(50 + i);
         cycle();
      end
      symb_val_i = 1'b0; start_i = 1'b1; symb_numb_i = 8'd8;
      cycle();
      start_i = 1'b0;
      checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL abort_level got %0d want 0", level_o); end
      checks++; if (out_val_o !== 1'b0) begin errors++; $display("FAIL abort_out_val got %0b want 0", out_val_o); end
      checks++; if (msg_done_o !== 1'b0) begin errors++; $display("FAIL abort_done got %0b want 0", msg_done_o); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy got %0b want 1", busy_o); end
      out_ready_i = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            checks++; if (symbol_o !== 7'(-i)) begin errors++; $display("FAIL abort_data[%0d] got %0d want %0d", i - 1, symbol_o, 7'(-i)); end
         end
         if (msg_done_o) dones++;
         if (i < 8) begin symb_val_i = 1'b1; symbol_i = 7'(-1 - i); end
         else symb_val_i = 1'b0;
         cycle();
      end
      for (int n = 0; n < 8; n++) begin
         if (out_val_o) extra++;
         if (msg_done_o) dones++;
         cycle();
      end
      checks++; if (extra !== 0) begin errors++; $display("FAIL abort_extra_out got %0d want 0", extra); end
      checks++; if (dones !== 1) begin errors++; $display("FAIL abort_done_pulses got %0d want 1", dones); end

      start_i = 1'b1; symb_numb_i = 8'd4; out_ready_i = 1'b0;
      cycle();
      start_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         symb_val_i = 1'b1; symbol_i = 7'(20 + i);
         cycle();
      end
      symb_val_i = 1'b0;
      cycle();
      checks++; if (level_o !== 5'd4) begin errors++; $display("FAIL rst_pre_level got %0d want 4", level_o); end
      rst_i = 1'b0;
      #1;
      checks++; if (out_val_o !== 1'b0) begin errors++; $display("FAIL rst_out_val got %0b want 0", out_val_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy_o); end
      checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level_o); end
      checks++; if (symbol_o !== 7'sd0) begin errors++; $display("FAIL rst_symbol got %0d want 0", symbol_o); end
      checks++; if (msg_done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", msg_done_o); end
      cycle();
      rst_i = 1'b1;
      cycle();
      checks++; if (msg_done_o !== 1'b0) begin errors++; $display("FAIL rst_done_after got %0b want 0", msg_done_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_empty_msg();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "watchdog");
   end

endmodule
